nco_ctrl_fsm: RTL and testbench

- NCO control FSM that sits between main_fsm and the NCO datapath.
- Streams 8-bit waveform samples from a valid/ready source into the NCO wave-table RAM.
- Arms the phase accumulator: latches the frequency step and clears the phase.
- Runs the NCO at a fixed step, or with an optional saturating linear frequency sweep; main_fsm drives commands and observes busy/done.

---
 rtl/nco_ctrl_pkg.sv | 17 +
 rtl/nco_ctrl_fsm_if.sv | 47 ++++
 rtl/nco_sweep_step.sv | 47 ++++
 rtl/nco_ctrl_fsm.sv | 173 +++++++++++++++++
 tb/tb_nco_ctrl_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO control FSM and its sweep helper.
package nco_ctrl_pkg;

  localparam int unsigned NCO_ADDR_W  = 8;
  localparam int unsigned NCO_DATA_W  = 8;
  localparam int unsigned NCO_STEP_W  = 14;
  localparam int unsigned SWEEP_DIV_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_SWEEP = 3'd4
  } state_t;

endpackage

// File: rtl/nco_ctrl_fsm_if.sv
// Command, sample-stream and NCO datapath signals between main_fsm/source and the NCO controller.
interface nco_ctrl_fsm_if
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = NCO_ADDR_W,
  parameter int unsigned DATA_W = NCO_DATA_W,
  parameter int unsigned STEP_W = NCO_STEP_W,
  parameter int unsigned DIV_W  = SWEEP_DIV_W
) ();

  logic              en_i;
  logic              abort_i;
  logic              load_start_i;
  logic              smp_valid_i;
  logic [DATA_W-1:0] smp_data_i;
  logic              smp_ready_o;
  logic              run_i;
  logic [STEP_W-1:0] freq_step_i;
  logic              sweep_en_i;
  logic [STEP_W-1:0] sweep_end_i;
  logic [STEP_W-1:0] sweep_inc_i;
  logic [DIV_W-1:0]  sweep_div_i;
  logic              nco_we_o;
  logic [ADDR_W-1:0] nco_addr_o;
  logic [DATA_W-1:0] nco_data_o;
  logic [STEP_W-1:0] nco_freq_step_o;
  logic              nco_phase_clr_o;
  logic              nco_run_o;
  logic              busy_o;
  logic              load_done_o;
  logic              sweep_done_o;

  modport master (
    output en_i, abort_i, load_start_i, smp_valid_i, smp_data_i, run_i, freq_step_i,
           sweep_en_i, sweep_end_i, sweep_inc_i, sweep_div_i,
    input  smp_ready_o, nco_we_o, nco_addr_o, nco_data_o, nco_freq_step_o, nco_phase_clr_o,
           nco_run_o, busy_o, load_done_o, sweep_done_o
  );

  modport slave (
    input  en_i, abort_i, load_start_i, smp_valid_i, smp_data_i, run_i, freq_step_i,
           sweep_en_i, sweep_end_i, sweep_inc_i, sweep_div_i,
    output smp_ready_o, nco_we_o, nco_addr_o, nco_data_o, nco_freq_step_o, nco_phase_clr_o,
           nco_run_o, busy_o, load_done_o, sweep_done_o
  );

endinterface

// File: rtl/nco_sweep_step.sv
// Sweep tick divider plus saturating step adder; the FSM owns the step register itself.
module nco_sweep_step #(
  parameter int unsigned STEP_W = 14,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [STEP_W-1:0] inc_i,
  input  logic [STEP_W-1:0] end_i,
  output logic              tick_o,
  output logic [STEP_W-1:0] step_o,
  output logic              reach_end_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [STEP_W:0]  sum;

  // >= rather than == so a period shortened mid-sweep still produces a tick.
  assign tick_o = en_i & (div_cnt_q >= div_i);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // One extra bit keeps the sum from wrapping past the end step.
  assign sum         = {1'b0, step_i} + {1'b0, inc_i};
  assign reach_end_o = (inc_i == '0) | (sum >= {1'b0, end_i});
  assign step_o      = reach_end_o ? end_i : sum[STEP_W-1:0];

endmodule

// File: rtl/nco_ctrl_fsm.sv
// NCO control FSM: wave-table load from a sample stream, phase arm, fixed-step run and
// linear frequency sweep. Every output is a flop loaded from next-state logic.
module nco_ctrl_fsm
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = NCO_ADDR_W,
  parameter int unsigned DATA_W = NCO_DATA_W,
  parameter int unsigned STEP_W = NCO_STEP_W,
  parameter int unsigned DIV_W  = SWEEP_DIV_W
) (
  input  logic           clk,
  input  logic           reset_n,
  nco_ctrl_fsm_if.slave  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              clr_q, clr_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              ld_done_q, ld_done_d;
  logic              sw_done_q, sw_done_d;

  logic              ovr;
  logic              hs;
  logic              div_clr;
  logic              sw_en;
  logic              tick;
  logic              reach_end;
  logic [STEP_W-1:0] sweep_next;

  assign ovr     = ~bus.en_i | bus.abort_i;
  assign hs      = bus.smp_valid_i & ready_q;
  assign div_clr = (state_q == S_ARM);
  assign sw_en   = (state_q == S_SWEEP) & ~ovr & bus.run_i;

  nco_sweep_step #(
    .STEP_W (STEP_W),
    .DIV_W  (DIV_W)
  ) u_sweep (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (div_clr),
    .en_i        (sw_en),
    .div_i       (bus.sweep_div_i),
    .step_i      (step_q),
    .inc_i       (bus.sweep_inc_i),
    .end_i       (bus.sweep_end_i),
    .tick_o      (tick),
    .step_o      (sweep_next),
    .reach_end_o (reach_end)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    step_d    = step_q;
    we_d      = 1'b0;
    ready_d   = 1'b0;
    clr_d     = 1'b0;
    ld_done_d = 1'b0;
    sw_done_d = 1'b0;

    if (ovr) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Load wins over run; run_i is seen again once the load returns here.
          if (bus.load_start_i) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else if (bus.run_i) begin
            state_d = S_ARM;
            step_d  = bus.freq_step_i;
            clr_d   = 1'b1;
          end
        end
        S_LOAD: begin
          ready_d = 1'b1;
          if (hs) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = bus.smp_data_i;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              ready_d   = 1'b0;
              ld_done_d = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        S_ARM: begin
          state_d = bus.sweep_en_i ? S_SWEEP : S_RUN;
        end
        S_RUN: begin
          if (!bus.run_i) begin
            state_d = S_IDLE;
          end else begin
            step_d = bus.freq_step_i;
          end
        end
        S_SWEEP: begin
          if (!bus.run_i) begin
            state_d = S_IDLE;
          end else if (tick) begin
            step_d = sweep_next;
            if (reach_end) begin
              sw_done_d = 1'b1;
              state_d   = S_RUN;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    run_d  = (state_d == S_RUN) | (state_d == S_SWEEP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      step_q    <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      clr_q     <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      ld_done_q <= 1'b0;
      sw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      step_q    <= step_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      clr_q     <= clr_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      ld_done_q <= ld_done_d;
      sw_done_q <= sw_done_d;
    end
  end

  assign bus.smp_ready_o     = ready_q;
  assign bus.nco_we_o        = we_q;
  assign bus.nco_addr_o      = addr_q;
  assign bus.nco_data_o      = data_q;
  assign bus.nco_freq_step_o = step_q;
  assign bus.nco_phase_clr_o = clr_q;
  assign bus.nco_run_o       = run_q;
  assign bus.busy_o          = busy_q;
  assign bus.load_done_o     = ld_done_q;
  assign bus.sweep_done_o    = sw_done_q;

endmodule

// File: tb/tb_nco_ctrl_fsm.sv
// Scoreboard bench for nco_ctrl_fsm: expected table writes and step updates are queued by the
// stimulus and popped by a negedge monitor whenever the DUT presents a write or a step change.
module tb_nco_ctrl_fsm;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  typedef struct packed {
    logic [13:0] val;
    logic        done;
    logic [15:0] gap;
  } st_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  wr_t  wq[$];
  st_t  sq[$];

  nco_ctrl_fsm_if bus ();

  nco_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards when the DUT writes the table or changes its step.
  logic [13:0] prev_step;
  int          last_chg;
  wr_t         we_e;
  st_t         st_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_step = '0;
      last_chg  = cyc;
    end else begin
      if (bus.nco_we_o) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: addr=0x%0h data=0x%0h, expected no write",
                   bus.nco_addr_o, bus.nco_data_o);
        end else begin
          we_e = wq.pop_front();
          chk("write addr", bus.nco_addr_o, we_e.addr);
          chk("write data", bus.nco_data_o, we_e.data);
          chk("load_done with write", bus.load_done_o, we_e.last);
        end
      end else if (bus.load_done_o) begin
        checks++;
        errors++;
        $display("FAIL load_done without write: got 1, expected 0");
      end
      if (bus.nco_freq_step_o !== prev_step || bus.sweep_done_o) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected step update: step=0x%0h done=%0d, expected none",
                   bus.nco_freq_step_o, bus.sweep_done_o);
        end else begin
          st_e = sq.pop_front();
          chk("step value", bus.nco_freq_step_o, st_e.val);
          chk("sweep_done with step", bus.sweep_done_o, st_e.done);
          if (st_e.gap != 0) chk("step update interval", cyc - last_chg, st_e.gap);
        end
        prev_step = bus.nco_freq_step_o;
        last_chg  = cyc;
      end
    end
  end

  task automatic send(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.smp_valid_i = 1'b1;
    bus.smp_data_i  = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.smp_ready_o) ok = 1'b1;
      @(negedge clk);
    end
    bus.smp_valid_i = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load_start_i = 1'b1;
    @(negedge clk);
    bus.load_start_i = 1'b0;
  endtask

  task automatic push_step(input logic [13:0] v, input logic d, input logic [15:0] g);
    sq.push_back('{val: v, done: d, gap: g});
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.sweep_done_o) got = 1'b1;
    end
    chk(name, got, 1);
  endtask

  task automatic sweep_setup(input logic [13:0] start, input logic [13:0] inc,
                             input logic [13:0] stop, input logic [15:0] div);
    bus.freq_step_i = start;
    bus.sweep_inc_i = inc;
    bus.sweep_end_i = stop;
    bus.sweep_div_i = div;
    bus.sweep_en_i  = 1'b1;
    bus.run_i       = 1'b1;
  endtask

  task automatic stop_run();
    bus.run_i = 1'b0;
    @(negedge clk);
    chk("run low after stop", bus.nco_run_o, 0);
    @(negedge clk);
    chk("step queue drained", sq.size(), 0);
  endtask

  int acc;
  bit ok;
  bit seen;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.en_i = 1'b0;        bus.abort_i = 1'b0;     bus.load_start_i = 1'b0;
    bus.smp_valid_i = 1'b0; bus.smp_data_i = '0;    bus.run_i = 1'b0;
    bus.freq_step_i = '0;   bus.sweep_en_i = 1'b0;  bus.sweep_end_i = '0;
    bus.sweep_inc_i = '0;   bus.sweep_div_i = '0;
    repeat (3) @(negedge clk);
    chk("reset we", bus.nco_we_o, 0);
    chk("reset ready", bus.smp_ready_o, 0);
    chk("reset run", bus.nco_run_o, 0);
    chk("reset busy", bus.busy_o, 0);
    chk("reset step", bus.nco_freq_step_o, 0);
    chk("reset addr", bus.nco_addr_o, 0);
    rst_n    = 1'b1;
    bus.en_i = 1'b1;
    @(negedge clk);

    // Full 256-sample load with valid held high.
    for (int i = 0; i < 256; i++) wq.push_back('{addr: 8'(i), data: 8'(i) ^ 8'hA5, last: (i == 255)});
    pulse_load();
    chk("ready after load start", bus.smp_ready_o, 1);
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      send(8'(i) ^ 8'hA5, ok);
      acc += int'(ok);
    end
    chk("samples accepted", acc, 256);
    chk("ready low after full load", bus.smp_ready_o, 0);
    @(negedge clk);
    chk("busy low after full load", bus.busy_o, 0);
    chk("write queue drained (full)", wq.size(), 0);

    // Backpressured load, aborted when sample 17 is offered.
    for (int i = 0; i < 17; i++) wq.push_back('{addr: 8'(i), data: 8'(i) ^ 8'h3C, last: 1'b0});
    pulse_load();
    for (int i = 0; i < 17; i++) begin
      send(8'(i) ^ 8'h3C, ok);
      @(negedge clk);
    end
    bus.smp_valid_i = 1'b1;
    bus.smp_data_i  = 8'd17 ^ 8'h3C;
    bus.abort_i     = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("ready low after abort", bus.smp_ready_o, 0);
    chk("busy low after abort", bus.busy_o, 0);
    repeat (4) @(negedge clk);
    bus.smp_valid_i = 1'b0;
    chk("write queue drained (abort)", wq.size(), 0);

    // New load restarts at addr 0, then en_i drop ends it.
    wq.push_back('{addr: 8'd0, data: 8'h11, last: 1'b0});
    wq.push_back('{addr: 8'd1, data: 8'h22, last: 1'b0});
    pulse_load();
    send(8'h11, ok);
    send(8'h22, ok);
    bus.en_i        = 1'b0;
    bus.smp_valid_i = 1'b1;
    bus.smp_data_i  = 8'h33;
    @(negedge clk);
    chk("ready low after en drop", bus.smp_ready_o, 0);
    repeat (3) @(negedge clk);
    bus.en_i        = 1'b1;
    bus.smp_valid_i = 1'b0;
    @(negedge clk);
    chk("write queue drained (en)", wq.size(), 0);

    // Arm and run at a fixed step, then live retune.
    push_step(14'h0100, 1'b0, 16'd0);
    bus.freq_step_i = 14'h0100;
    bus.sweep_en_i  = 1'b0;
    bus.run_i       = 1'b1;
    @(negedge clk);
    chk("arm phase_clr", bus.nco_phase_clr_o, 1);
    chk("arm run", bus.nco_run_o, 0);
    chk("arm busy", bus.busy_o, 1);
    @(negedge clk);
    chk("run phase_clr", bus.nco_phase_clr_o, 0);
    chk("run active", bus.nco_run_o, 1);
    push_step(14'h0200, 1'b0, 16'd0);
    bus.freq_step_i = 14'h0200;
    @(negedge clk);
    chk("retune latency", bus.nco_freq_step_o, 14'h0200);
    bus.load_start_i = 1'b1;
    @(negedge clk);
    bus.load_start_i = 1'b0;
    chk("load ignored in run", bus.smp_ready_o, 0);
    chk("still running", bus.nco_run_o, 1);
    stop_run();
    chk("busy low after run", bus.busy_o, 0);

    // Sweep 100 -> 200 by 30 every 4 cycles, then tracking freq_step_i.
    push_step(14'd100, 1'b0, 16'd0);
    push_step(14'd130, 1'b0, 16'd0);
    push_step(14'd160, 1'b0, 16'd4);
    push_step(14'd190, 1'b0, 16'd4);
    push_step(14'd200, 1'b1, 16'd4);
    push_step(14'd100, 1'b0, 16'd1);
    sweep_setup(14'd100, 14'd30, 14'd200, 16'd3);
    wait_done("sweep_done seen");
    chk("step at sweep_done", bus.nco_freq_step_o, 14'd200);
    @(negedge clk);
    chk("run after sweep", bus.nco_run_o, 1);
    chk("busy after sweep", bus.busy_o, 1);
    stop_run();

    // Start above end: first tick lands on end.
    push_step(14'd300, 1'b0, 16'd0);
    push_step(14'd200, 1'b1, 16'd2);
    push_step(14'd300, 1'b0, 16'd1);
    sweep_setup(14'd300, 14'd30, 14'd200, 16'd0);
    wait_done("sweep_done start>end");
    @(negedge clk);
    stop_run();

    // Zero increment: first tick lands on end.
    push_step(14'd100, 1'b0, 16'd0);
    push_step(14'd200, 1'b1, 16'd3);
    push_step(14'd100, 1'b0, 16'd1);
    sweep_setup(14'd100, 14'd0, 14'd200, 16'd1);
    wait_done("sweep_done inc=0");
    @(negedge clk);
    stop_run();

    // en_i dropped mid-sweep: stop next cycle, no further ticks or done.
    push_step(14'd50, 1'b0, 16'd0);
    push_step(14'd60, 1'b0, 16'd5);
    sweep_setup(14'd50, 14'd10, 14'd200, 16'd3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.nco_freq_step_o == 14'd60) seen = 1'b1;
    end
    chk("first sweep tick seen", seen, 1);
    @(negedge clk);
    bus.en_i = 1'b0;
    @(negedge clk);
    chk("run low after en drop", bus.nco_run_o, 0);
    chk("busy low after en drop", bus.busy_o, 0);
    repeat (8) @(negedge clk);
    chk("step held after en drop", bus.nco_freq_step_o, 14'd60);
    bus.run_i      = 1'b0;
    bus.sweep_en_i = 1'b0;
    bus.en_i       = 1'b1;
    @(negedge clk);
    chk("step queue drained (en)", sq.size(), 0);

    // Asynchronous reset in the middle of a run.
    push_step(14'h0123, 1'b0, 16'd0);
    bus.freq_step_i = 14'h0123;
    bus.run_i       = 1'b1;
    repeat (3) @(negedge clk);
    chk("running before reset", bus.nco_run_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset run", bus.nco_run_o, 0);
    chk("async reset step", bus.nco_freq_step_o, 0);
    chk("async reset busy", bus.busy_o, 0);
    bus.run_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("final write queue empty", wq.size(), 0);
    chk("final step queue empty", sq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
